shape_write: RTL and testbench
==============================

SHAPE_WRITE -- requirements
Module: shape_write

Interface
REQ-001 SHALL have parameter DATAB, default 3, log2 of words per shape record (8 words).
REQ-002 SHALL have parameter CORDW, default 10, coordinate width.
REQ-003 SHALL have parameter ADDRW, default 20, RAM address width.
REQ-004 SHALL have parameter DATAW, default 12, RAM word width.
REQ-005 SHALL have parameter NUMW, default DATAW, shape id width.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port id  input  NUMW  target shape slot.
REQ-009 SHALL have ports ty, size, rotate  input  DATAW each, and x, y  input  CORDW each, record fields.
REQ-010 SHALL have port req_valid  input  1  write request.
REQ-011 SHALL have port req_ready  output  1  request can be accepted.
REQ-012 SHALL have port ram_address_offset  input  ADDRW  base of shape table.
REQ-013 SHALL have port ram_address  output  ADDRW  write address.
REQ-014 SHALL have port ram_enable  output  1  write enable.
REQ-015 SHALL have port ram_data  output  DATAW  write data.
REQ-016 SHALL have ports busy  output  1  (state not IDLE) and done  output  1  (one-cycle completion pulse).

Function
REQ-017 SHALL use states IDLE, WRITE, DONE; req_ready = (state == IDLE).
REQ-018 SHALL accept a request on an edge where req_valid && req_ready, capturing id, ram_address_offset and all fields into internal registers, clearing ptr to 0, entering WRITE.
REQ-019 SHALL ignore req_valid outside IDLE; captured values SHALL NOT change until the next acceptance.
REQ-020 SHALL in WRITE drive ram_enable = 1, ram_address = (id_q << DATAB) + offset_q + ptr, truncated modulo 2^ADDRW.
REQ-021 SHALL drive ram_data by ptr: 0 ty, 1 x zero-extended to DATAW, 2 y zero-extended, 3 size, 4 rotate, 5..7 zero.
REQ-022 SHALL increment ptr each WRITE cycle; after the last word go to DONE with ram_enable = 0.
REQ-023 SHALL assert done for exactly the single DONE cycle, then return to IDLE.
REQ-024 SHALL, for an acceptance edge at cycle N, issue words in cycles N+1..N+L (L = 8 or 5, see Configuration), done in N+L+1, req_ready high in N+L+2.
REQ-025 SHALL drive ram_enable = 0, ram_address = 0 and ram_data = 0 whenever not in WRITE.

Reset
REQ-026 SHALL on rst_n low immediately force state IDLE, ptr 0, captured registers 0, ram_enable 0, done 0, busy 0.
REQ-027 SHALL, on reset mid-WRITE, abandon the record without a done pulse; the partially written record is not repaired.
REQ-028 SHALL raise req_ready in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL, with SHAPE_WRITE_PAD_EN defined, write all 2^DATAB words (L = 8), words 5..7 zero.
REQ-030 SHALL, without SHAPE_WRITE_PAD_EN, write only words 0..4 (L = 5) and leave slots 5..7 untouched.

Structure
REQ-031 SHALL take word-index constants (WORD_TY=0, WORD_X=1, WORD_Y=2, WORD_SIZE=3, WORD_ROTATE=4) and the state enum from shared package shape_pkg, which the shape reader also uses.
REQ-032 SHALL be a single module; no sub-module is warranted.

Verification
REQ-033 SHALL check: id=3, offset=0x100, ty=2, x=0x155, y=0x0AA, size=40, rotate=3, PAD on -> writes 0x118..0x11F = 2,0x155,0x0AA,40,3,0,0,0; done at N+9.
REQ-034 SHALL check: same stimulus, PAD off -> writes 0x118..0x11C only, done at N+6, no enable at 0x11D.
REQ-035 SHALL check: second req_valid held during WRITE with different id -> ignored, first record intact, second accepted only when req_ready returns.
REQ-036 SHALL check: rst_n low at the third write cycle -> ram_enable 0 same cycle, no done, req_ready 1 after release.
REQ-037 SHALL check: id=0xFFF, offset=0xFFFF0, DATAB=3 -> addresses wrap modulo 2^20 (0x7FE8..).
REQ-038 SHALL check: shape_write then the shape reader on the same RAM and id -> read ty/x/y/size/rotate equal the written values.

Source files
------------

// File: rtl/shape_pkg.sv
// Shared definitions for the shape table writer and reader.
// Holds the record word layout and the writer/reader state encoding.
package shape_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } shape_state_e;

  // Word positions inside one shape record
  localparam int WORD_TY     = 0;
  localparam int WORD_X      = 1;
  localparam int WORD_Y      = 2;
  localparam int WORD_SIZE   = 3;
  localparam int WORD_ROTATE = 4;

endpackage

// File: rtl/shape_write.sv
// shape_write: writes one shape record into a RAM-resident shape table.
// A record occupies 2^DATAB words starting at (id << DATAB) + offset.
// Optional feature macro SHAPE_WRITE_PAD_EN: when defined, the unused tail
// words of the record are written as zero; otherwise only words 0..4 are
// written and the tail slots are left untouched.
// All outputs are registered; their next values are derived from the
// next-state values so that word k appears k+1 cycles after acceptance.
module shape_write
  import shape_pkg::*;
#(
  parameter int DATAB = 3,
  parameter int CORDW = 10,
  parameter int ADDRW = 20,
  parameter int DATAW = 12,
  parameter int NUMW  = DATAW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUMW-1:0]  id,
  input  logic [DATAW-1:0] ty,
  input  logic [CORDW-1:0] x,
  input  logic [CORDW-1:0] y,
  input  logic [DATAW-1:0] size,
  input  logic [DATAW-1:0] rotate,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ADDRW-1:0] ram_address_offset,
  output logic [ADDRW-1:0] ram_address,
  output logic             ram_enable,
  output logic [DATAW-1:0] ram_data,
  output logic             busy,
  output logic             done
);

`ifdef SHAPE_WRITE_PAD_EN
  localparam int LAST_WORD = (1 << DATAB) - 1;
`else
  localparam int LAST_WORD = WORD_ROTATE;
`endif
  localparam logic [DATAB-1:0] LAST_PTR = DATAB'(LAST_WORD);

  shape_state_e     state_q, state_d;
  logic [DATAB-1:0] ptr_q, ptr_d;
  logic [NUMW-1:0]  id_q, id_d;
  logic [ADDRW-1:0] offset_q, offset_d;
  logic [DATAW-1:0] ty_q, ty_d;
  logic [CORDW-1:0] x_q, x_d;
  logic [CORDW-1:0] y_q, y_d;
  logic [DATAW-1:0] size_q, size_d;
  logic [DATAW-1:0] rotate_q, rotate_d;
  logic             ram_enable_q, ram_enable_d;
  logic [ADDRW-1:0] ram_address_q, ram_address_d;
  logic [DATAW-1:0] ram_data_q, ram_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             req_ready_q, req_ready_d;

  // Next-state, word pointer and request capture
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    offset_d = offset_q;
    ty_d     = ty_q;
    x_d      = x_q;
    y_d      = y_q;
    size_d   = size_q;
    rotate_d = rotate_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          id_d     = id;
          offset_d = ram_address_offset;
          ty_d     = ty;
          x_d      = x;
          y_d      = y;
          size_d   = size;
          rotate_d = rotate;
          ptr_d    = '0;
          state_d  = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (ptr_q == LAST_PTR) begin
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + DATAB'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    ram_enable_d  = (state_d == ST_WRITE);
    ram_address_d = '0;
    ram_data_d    = '0;
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
    req_ready_d   = (state_d == ST_IDLE);
    if (ram_enable_d) begin
      ram_address_d = (ADDRW'(id_d) << DATAB) + offset_d + ADDRW'(ptr_d);
      case (ptr_d)
        DATAB'(WORD_TY):     ram_data_d = ty_d;
        DATAB'(WORD_X):      ram_data_d = DATAW'(x_d);
        DATAB'(WORD_Y):      ram_data_d = DATAW'(y_d);
        DATAB'(WORD_SIZE):   ram_data_d = size_d;
        DATAB'(WORD_ROTATE): ram_data_d = rotate_d;
        default:             ram_data_d = '0;
      endcase
    end else begin
      ram_address_d = '0;
      ram_data_d    = '0;
    end
  end

  // State, captured record and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      id_q          <= '0;
      offset_q      <= '0;
      ty_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      size_q        <= '0;
      rotate_q      <= '0;
      ram_enable_q  <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      req_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      offset_q      <= offset_d;
      ty_q          <= ty_d;
      x_q           <= x_d;
      y_q           <= y_d;
      size_q        <= size_d;
      rotate_q      <= rotate_d;
      ram_enable_q  <= ram_enable_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      req_ready_q   <= req_ready_d;
    end
  end

  assign ram_enable  = ram_enable_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign req_ready   = req_ready_q;

endmodule

// File: tb/tb_shape_write.sv
// Self-checking bench for shape_write. Expected RAM writes and done pulses
// are pushed to scoreboard queues when a request is driven; a monitor
// records what the DUT actually does and each test drains and compares.
module tb_shape_write;

  localparam int DATAB = 3;
  localparam int CORDW = 10;
  localparam int ADDRW = 20;
  localparam int DATAW = 12;
  localparam int NUMW  = 12;
`ifdef SHAPE_WRITE_PAD_EN
  localparam int L = 8;
`else
  localparam int L = 5;
`endif

  logic             clk;
  logic             rst_n;
  logic [NUMW-1:0]  id;
  logic [DATAW-1:0] ty;
  logic [CORDW-1:0] x;
  logic [CORDW-1:0] y;
  logic [DATAW-1:0] size;
  logic [DATAW-1:0] rotate;
  logic             req_valid;
  logic             req_ready;
  logic [ADDRW-1:0] ram_address_offset;
  logic [ADDRW-1:0] ram_address;
  logic             ram_enable;
  logic [DATAW-1:0] ram_data;
  logic             busy;
  logic             done;

  shape_write #(
    .DATAB(DATAB), .CORDW(CORDW), .ADDRW(ADDRW), .DATAW(DATAW), .NUMW(NUMW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id(id), .ty(ty), .x(x), .y(y), .size(size),
    .rotate(rotate), .req_valid(req_valid), .req_ready(req_ready),
    .ram_address_offset(ram_address_offset), .ram_address(ram_address),
    .ram_enable(ram_enable), .ram_data(ram_data), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] data;
  } wr_t;

  wr_t              exp_q[$];
  wr_t              obs_q[$];
  int               exp_done_q[$];
  int               done_q[$];
  logic [DATAW-1:0] mem[int];
  int               idle_bad = 0;
  int               errors = 0;
  int               checks = 0;

  // Monitor: record writes, done pulses and idle-bus violations
  always @(negedge clk) begin
    if (ram_enable === 1'b1) begin
      obs_q.push_back('{cyc, ram_address, ram_data});
      mem[int'(ram_address)] = ram_data;
    end else if (ram_address !== '0 || ram_data !== '0) begin
      idle_bad++;
    end
    if (done === 1'b1) done_q.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATAW-1:0] exp_word(int k, logic [DATAW-1:0] f_ty,
      logic [CORDW-1:0] f_x, logic [CORDW-1:0] f_y, logic [DATAW-1:0] f_sz,
      logic [DATAW-1:0] f_rot);
    case (k)
      0: return f_ty;
      1: return {2'b00, f_x};
      2: return {2'b00, f_y};
      3: return f_sz;
      4: return f_rot;
      default: return 12'h000;
    endcase
  endfunction

  task automatic push_expected(logic [NUMW-1:0] f_id, logic [ADDRW-1:0] f_off,
      logic [DATAW-1:0] f_ty, logic [CORDW-1:0] f_x, logic [CORDW-1:0] f_y,
      logic [DATAW-1:0] f_sz, logic [DATAW-1:0] f_rot, int n, int count,
      bit with_done);
    for (int k = 0; k < count; k++) begin
      logic [31:0] a;
      a = (32'(f_id) << DATAB) + 32'(f_off) + 32'(k);
      exp_q.push_back('{n + 1 + k, a[ADDRW-1:0],
                        exp_word(k, f_ty, f_x, f_y, f_sz, f_rot)});
    end
    if (with_done) exp_done_q.push_back(n + L + 1);
  endtask

  task automatic do_req(logic [NUMW-1:0] f_id, logic [ADDRW-1:0] f_off,
      logic [DATAW-1:0] f_ty, logic [CORDW-1:0] f_x, logic [CORDW-1:0] f_y,
      logic [DATAW-1:0] f_sz, logic [DATAW-1:0] f_rot, bit push, output int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #1;
      if (req_ready === 1'b1) ok = 1'b1;
    end
    n = cyc;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_wait: req_ready=%b required 1 within 50 cycles", req_ready);
    end else begin
      id = f_id; ram_address_offset = f_off; ty = f_ty; x = f_x; y = f_y;
      size = f_sz; rotate = f_rot; req_valid = 1'b1;
      if (push) push_expected(f_id, f_off, f_ty, f_x, f_y, f_sz, f_rot, n, L, 1'b1);
    end
  endtask

  task automatic release_req();
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_cycles(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic scoreboard_drain(string name);
    bit bad;
    while (exp_q.size() > 0) begin
      wr_t e;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s_write: no write seen, required cyc=%0d addr=%h data=%h",
                 name, e.cyc, e.addr, e.data);
      end else begin
        wr_t o;
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data) begin
          errors++;
          $display("FAIL %s_write: got cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=%h",
                   name, o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
        end
      end
    end
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_extra: %0d unexpected writes, first addr=%h, required none",
               name, obs_q.size(), obs_q[0].addr);
    end
    obs_q.delete();
    checks++;
    bad = (done_q.size() != exp_done_q.size());
    for (int i = 0; i < done_q.size() && !bad; i++) bad = (done_q[i] != exp_done_q[i]);
    if (bad) begin
      errors++;
      $display("FAIL %s_done: got %0d pulses (first cyc=%0d), required %0d (first cyc=%0d)",
               name, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1,
               exp_done_q.size(), (exp_done_q.size() > 0) ? exp_done_q[0] : -1);
    end
    done_q.delete();
    exp_done_q.delete();
    checks++;
    if (idle_bad !== 0) begin
      errors++;
      $display("FAIL %s_idle_bus: %0d idle cycles with nonzero addr/data, required 0",
               name, idle_bad);
    end
    idle_bad = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run_cycles(3);
    checks++; if (ram_enable !== 1'b0) begin errors++; $display("FAIL rst_enable: got %b required 0", ram_enable); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (ram_address !== 20'h00000) begin errors++; $display("FAIL rst_addr: got %h required 0", ram_address); end
    checks++; if (ram_data !== 12'h000) begin errors++; $display("FAIL rst_data: got %h required 0", ram_data); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", req_ready); end
    obs_q.delete(); done_q.delete(); idle_bad = 0;
  endtask

  task automatic test_record();
    int n;
    do_req(12'h003, 20'h00100, 12'd2, 10'h155, 10'h0AA, 12'd40, 12'd3, 1'b1, n);
    release_req();
    run_cycles(L + 4);
`ifdef SHAPE_WRITE_PAD_EN
    checks++;
    if (!mem.exists(32'h11D) || mem[32'h11D] !== 12'h000) begin
      errors++; $display("FAIL pad_word5: slot 0x11D not written with 0, required 0");
    end
`else
    checks++;
    if (mem.exists(32'h11D)) begin
      errors++; $display("FAIL nopad_word5: slot 0x11D written with %h, required untouched", mem[32'h11D]);
    end
`endif
    scoreboard_drain("record");
  endtask

  task automatic test_ignore();
    int n1, n2;
    do_req(12'h003, 20'h00100, 12'd2, 10'h155, 10'h0AA, 12'd40, 12'd3, 1'b1, n1);
    @(negedge clk); #1;
    id = 12'h005; ty = 12'd7; x = 10'h3FF; y = 10'h001; size = 12'd9; rotate = 12'd1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ign_ready: got %b required 0", req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b required 1", busy); end
    n2 = n1 + L + 2;
    push_expected(12'h005, 20'h00100, 12'd7, 10'h3FF, 10'h001, 12'd9, 12'd1, n2, L, 1'b1);
    while (cyc <= n2) begin
      @(negedge clk); #1;
    end
    req_valid = 1'b0;
    run_cycles(L + 4);
    scoreboard_drain("ignore");
  endtask

  task automatic test_reset_mid();
    int n;
    do_req(12'h001, 20'h00000, 12'h011, 10'h022, 10'h033, 12'h044, 12'h055, 1'b0, n);
    push_expected(12'h001, 20'h00000, 12'h011, 10'h022, 10'h033, 12'h044, 12'h055, n, 3, 1'b0);
    release_req();
    while (cyc < n + 3) begin
      @(negedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (ram_enable !== 1'b0) begin errors++; $display("FAIL midrst_enable: got %b required 0", ram_enable); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
    run_cycles(2);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b required 1", req_ready); end
    run_cycles(L + 2);
    scoreboard_drain("midrst");
  endtask

  task automatic test_wrap();
    int n;
    do_req(12'hFFF, 20'hFFFF0, 12'hABC, 10'h2A5, 10'h15A, 12'h123, 12'h456, 1'b1, n);
    release_req();
    run_cycles(L + 4);
    checks++;
    if (!mem.exists(32'h7FE8) || mem[32'h7FE8] !== 12'hABC) begin
      errors++; $display("FAIL wrap_first: slot 0x7FE8 missing or wrong, required ABC");
    end
    scoreboard_drain("wrap");
  endtask

  task automatic test_readback();
    logic [DATAW-1:0] want[5];
    want[0] = 12'd2; want[1] = 12'h155; want[2] = 12'h0AA; want[3] = 12'd40; want[4] = 12'd3;
    for (int k = 0; k < 5; k++) begin
      logic [DATAW-1:0] got;
      got = mem.exists(32'h118 + k) ? mem[32'h118 + k] : 12'hFFF;
      checks++;
      if (got !== want[k]) begin
        errors++; $display("FAIL readback_w%0d: got %h required %h", k, got, want[k]);
      end
    end
  endtask

  initial begin
    id = '0; ty = '0; x = '0; y = '0; size = '0; rotate = '0;
    req_valid = 1'b0; ram_address_offset = '0; rst_n = 1'b0;
    test_reset();
    test_record();
    test_ignore();
    test_reset_mid();
    test_wrap();
    test_readback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
